// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares one external combinational adder among N requesters. A winner is
//   picked in IDLE, its operands are presented on add_a/add_b for one EXEC
//   cycle, the adder result is registered, and the response is held in RESP
//   until the requester accepts it with rsp_ready.
//
//   Build option: define ADDER_ARBITER_FIXED_PRIO_EN to use fixed priority
//   (lowest asserted index wins). Without it, arbitration is round-robin,
//   starting the search one past the last granted requester.
//
// Ports
//   clk        clock, all state changes on rising edge
//   rst        asynchronous active-high reset
//   req        per-requester request (sampled only in IDLE)
//   op_a/op_b  packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt        one-hot grant, high for exactly one cycle (the EXEC cycle)
//   add_a/b    operands driven to the shared adder, held between operations
//   add_sum    adder result from outside, carry in MSB
//   rsp_valid  one-hot response valid, held until rsp_ready
//   rsp_data   registered adder result
//   rsp_ready  response accepted by the flagged requester
//   busy       high whenever the FSM is not in IDLE
//
// States
//   IDLE | waiting for a request; add_a/add_b keep their last values
//   EXEC | winner's operands on the adder, gnt high
//   RESP | result registered, rsp_valid held until rsp_ready
module adder_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] op_a,
    input  logic [N*WIDTH-1:0] op_b,
    output logic [N-1:0]       gnt,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    input  logic [WIDTH:0]     add_sum,
    output logic [N-1:0]       rsp_valid,
    output logic [WIDTH:0]     rsp_data,
    input  logic               rsp_ready,
    output logic               busy
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [N-1:0]     gnt_n, rsp_valid_n;
    logic [WIDTH-1:0] add_a_n, add_b_n;
    logic [WIDTH:0]   rsp_data_n;
    logic             busy_n;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_onehot;

`ifndef ADDER_ARBITER_FIXED_PRIO_EN
    logic [IDX_W-1:0] last_grant, last_grant_n;
    logic             win_found;
`endif

    // Winner selection
    always_comb begin
        win_idx = '0;
`ifdef ADDER_ARBITER_FIXED_PRIO_EN
        // Descending scan so the lowest asserted index is written last.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                win_idx = IDX_W'(k);
            end
        end
`else
        // Search begins one past the last grant and wraps N-1 -> 0.
        win_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!win_found && req[(int'(last_grant) + 1 + k) % N]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(last_grant) + 1 + k) % N);
            end
        end
`endif
        win_onehot = N'(1) << win_idx;
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        gnt_n       = '0;
        rsp_valid_n = rsp_valid;
        rsp_data_n  = rsp_data;
        add_a_n     = add_a;
        add_b_n     = add_b;
`ifndef ADDER_ARBITER_FIXED_PRIO_EN
        last_grant_n = last_grant;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_n   = win_onehot;
                    add_a_n = op_a[int'(win_idx)*WIDTH +: WIDTH];
                    add_b_n = op_b[int'(win_idx)*WIDTH +: WIDTH];
`ifndef ADDER_ARBITER_FIXED_PRIO_EN
                    last_grant_n = win_idx;
`endif
                    state_n = EXEC;
                end
            end
            EXEC: begin
                // gnt still holds the winner's one-hot during EXEC.
                rsp_data_n  = add_sum;
                rsp_valid_n = gnt;
                state_n     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = '0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n     = IDLE;
                rsp_valid_n = '0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            add_a     <= '0;
            add_b     <= '0;
            busy      <= 1'b0;
`ifndef ADDER_ARBITER_FIXED_PRIO_EN
            // Makes requester 0 first in line after reset.
            last_grant <= IDX_W'(N - 1);
`endif
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            add_a     <= add_a_n;
            add_b     <= add_b_n;
            busy      <= busy_n;
`ifndef ADDER_ARBITER_FIXED_PRIO_EN
            last_grant <= last_grant_n;
`endif
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] op_a, op_b;
    logic [N-1:0]       gnt;
    logic [WIDTH-1:0]   add_a, add_b;
    logic [WIDTH:0]     add_sum;
    logic [N-1:0]       rsp_valid;
    logic [WIDTH:0]     rsp_data;
    logic               rsp_ready;
    logic               busy;

    int errors = 0;
    int checks = 0;
    int model_last = N - 1;

    logic [WIDTH-1:0] a_op [N];
    logic [WIDTH-1:0] b_op [N];

    adder_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy)
    );

    // Shared adder environment
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef ADDER_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation starting in an IDLE cycle; returns the winner index.
    task automatic do_op(input logic [N-1:0] r, input int dly, input bit keep, output int w);
        logic [WIDTH:0] exp_sum;
        logic [N-1:0]   oh;
        for (int i = 0; i < N; i++) begin
            op_a[i*WIDTH +: WIDTH] = a_op[i];
            op_b[i*WIDTH +: WIDTH] = b_op[i];
        end
        req       = r;
        rsp_ready = 1'b0;
        w         = pick(r, model_last);
        oh        = N'(1) << w;
        exp_sum   = {1'b0, a_op[w]} + {1'b0, b_op[w]};
        tick();
        check("gnt_t1", 32'(gnt), 32'(oh));
        check("busy_t1", 32'(busy), 32'd1);
        check("add_a_t1", 32'(add_a), 32'(a_op[w]));
        check("add_b_t1", 32'(add_b), 32'(b_op[w]));
        check("rsp_valid_t1", 32'(rsp_valid), 32'd0);
        if (!keep) req = '0;
        tick();
        check("gnt_t2", 32'(gnt), 32'd0);
        check("rsp_valid_t2", 32'(rsp_valid), 32'(oh));
        check("rsp_data_t2", 32'(rsp_data), 32'(exp_sum));
        for (int d = 0; d < dly; d++) begin
            tick();
            check("hold_valid", 32'(rsp_valid), 32'(oh));
            check("hold_data", 32'(rsp_data), 32'(exp_sum));
            check("hold_gnt", 32'(gnt), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_add_a", 32'(add_a), 32'(a_op[w]));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_t3", 32'(rsp_valid), 32'd0);
        check("busy_t3", 32'(busy), 32'd0);
        check("gnt_t3", 32'(gnt), 32'd0);
        check("add_a_idle", 32'(add_a), 32'(a_op[w]));
        check("rsp_data_idle", 32'(rsp_data), 32'(exp_sum));
        model_last = w;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_add_a"}, 32'(add_a), 32'd0);
        check({tag, "_add_b"}, 32'(add_b), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 check_reset_state("rst_pulse");
        tick();
        rst = 1'b0;
        model_last = N - 1;
    endtask

    initial begin
        int w;
        int exp_order [5];
        logic [N-1:0] rr;
        logic [WIDTH:0] prev_data;

        rst = 1'b1; req = '0; op_a = '0; op_b = '0; rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin a_op[i] = '0; b_op[i] = '0; end
        #1 check_reset_state("reset");
        tick(); tick();
        rst = 1'b0;
        tick();

        // rsp_ready without a pending response does nothing
        rsp_ready = 1'b1;
        tick(); tick();
        check("idle_ready_busy", 32'(busy), 32'd0);
        check("idle_ready_valid", 32'(rsp_valid), 32'd0);
        check("idle_ready_gnt", 32'(gnt), 32'd0);
        rsp_ready = 1'b0;

        // 0x0F + 0x01 for requester 2
        a_op[2] = 8'h0F; b_op[2] = 8'h01;
        do_op(4'b0100, 0, 1'b0, w);
        check("sum_0f_01", 32'(rsp_data), 32'h010);

        // carry out: 0xFF + 0x01
        a_op[0] = 8'hFF; b_op[0] = 8'h01;
        do_op(4'b0001, 0, 1'b0, w);
        check("sum_ff_01", 32'(rsp_data), 32'h100);

        // held all-request from a fresh reset
        pulse_reset();
        for (int i = 0; i < N; i++) begin a_op[i] = 8'(8'h10 * i + 3); b_op[i] = 8'(8'hF0 - i); end
`ifdef ADDER_ARBITER_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        for (int k = 0; k < 5; k++) begin
            do_op(4'b1111, 0, 1'b1, w);
            check("grant_order", 32'(w), 32'(exp_order[k]));
        end
        req = '0;
        tick();

        // long RESP hold with other requests pending
        a_op[1] = 8'h80; b_op[1] = 8'h80; a_op[3] = 8'h7F; b_op[3] = 8'h81;
        do_op(4'b1010, 5, 1'b1, w);
        do_op(4'b1010, 0, 1'b0, w);

        // reset during EXEC
        for (int i = 0; i < N; i++) op_a[i*WIDTH +: WIDTH] = a_op[i];
        req = 4'b0110;
        tick();
        check("exec_gnt_before_rst", 32'(|gnt), 32'd1);
        req = '0;
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_valid_after_rst", 32'(rsp_valid), 32'd0);
            check("idle_after_rst", 32'(busy), 32'd0);
        end
        do_op(4'b1111, 0, 1'b0, w);
        check("first_after_rst", 32'(w), 32'd0);

        // randomized operations
        for (int n = 0; n < 30; n++) begin
            rr = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                a_op[i] = WIDTH'($urandom);
                b_op[i] = WIDTH'($urandom);
            end
            do_op(rr, int'($urandom_range(0, 3)), 1'b0, w);
            prev_data = rsp_data;
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
                check("rand_idle_busy", 32'(busy), 32'd0);
                check("rand_idle_data", 32'(rsp_data), 32'(prev_data));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
